pc_seq_ctrl: RTL and testbench

- Control sequencer for the program-counter register; drives its hold bits `jon10[1:0]`, its branch-commit strobe `jon2` and its branch opcode `op_w`.
- Holds the PC while a control-flow instruction (ops 32–35, 40–42) travels from decode to the stage where `os`/`ot` are valid, then fires exactly one commit cycle.
- Detects load-use hazards in decode and freezes the PC for them.
- Keeps saturating performance counters for stall and branch cycles.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/pc_seq_ctrl_sat_counter.sv | 18 +
 rtl/pc_seq_ctrl.sv | 103 ++++++++++
 tb/tb_pc_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: sequencer states, control-flow opcodes and the
// control-flow classifier shared with the decoder.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHADOW  = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   localparam logic [5:0] OP_BEQ = 6'd32;
   localparam logic [5:0] OP_BNE = 6'd33;
   localparam logic [5:0] OP_BLT = 6'd34;
   localparam logic [5:0] OP_BLE = 6'd35;
   localparam logic [5:0] OP_J   = 6'd40;
   localparam logic [5:0] OP_JAL = 6'd41;
   localparam logic [5:0] OP_JR  = 6'd42;

   function automatic logic is_cf(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BLE) ||
             (op == OP_J)   || (op == OP_JAL) || (op == OP_JR);
   endfunction

endpackage

// File: rtl/pc_seq_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstd,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rstd) begin
      if (rstd)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: branch shadow hold, single commit strobe, load-use freeze and
// saturating stall/branch performance counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | PC advances; load-use hazard may hold it combinationally
//   SHADOW  | cf op in flight, PC held, decode killed (RESOLVE_LAT cycles)
//   RESOLVE | one-cycle commit strobe with captured opcode, decode killed
module pc_seq_ctrl
   import pipeline_pkg::*;
#(
   parameter int RESOLVE_LAT = 2,
   parameter int PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rstd,
   input  logic              valid_d,
   input  logic [5:0]        op_d,
   input  logic [4:0]        rs_d,
   input  logic [4:0]        rt_d,
   input  logic              uses_rs_d,
   input  logic              uses_rt_d,
   input  logic              load_e,
   input  logic [4:0]        rd_e,
   output logic [1:0]        jon10,
   output logic              jon2,
   output logic [5:0]        op_w,
   output logic              kill_d,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] branch_cnt
);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [5:0] op_q, op_nxt;
   logic       hazard;

   assign hazard = valid_d & load_e & (rd_e != 5'd0) &
                   ((uses_rs_d & (rs_d == rd_e)) | (uses_rt_d & (rt_d == rd_e)));

   always_ff @(posedge clk or posedge rstd) begin
      if (rstd) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_q  <= op_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_nxt    = op_q;
      jon10     = 2'b00;
      jon2      = 1'b0;
      kill_d    = 1'b0;
      unique case (state)
         IDLE: begin
            // Hazard wins: a cf op seen alongside a hazard is retried next cycle.
            jon10[1] = hazard;
            if (!hazard && valid_d && is_cf(op_d)) begin
               op_nxt    = op_d;
               cnt_nxt   = 3'(RESOLVE_LAT - 1);
               state_nxt = SHADOW;
            end
         end
         SHADOW: begin
            jon10  = 2'b01;
            kill_d = 1'b1;
            if (cnt == 3'd0)
               state_nxt = RESOLVE;
            else
               cnt_nxt = cnt - 3'd1;
         end
         RESOLVE: begin
            jon2      = 1'b1;
            kill_d    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign op_w = op_q;

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rstd  (rstd),
      .inc   (|jon10),
      .count (stall_cnt)
   );

   sat_counter #(.W(PERF_W)) u_branch_cnt (
      .clk   (clk),
      .rstd  (rstd),
      .inc   (jon2),
      .count (branch_cnt)
   );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: default instance plus a PERF_W=4 instance
// sharing the same stimulus for counter saturation.
module tb_pc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rstd;
   logic        valid_d;
   logic [5:0]  op_d;
   logic [4:0]  rs_d, rt_d, rd_e;
   logic        uses_rs_d, uses_rt_d, load_e;

   logic [1:0]  jon10, jon10_s;
   logic        jon2, jon2_s, kill_d, kill_d_s;
   logic [5:0]  op_w, op_w_s;
   logic [15:0] stall_cnt, branch_cnt;
   logic [3:0]  stall_cnt_s, branch_cnt_s;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pc_seq_ctrl #(.RESOLVE_LAT(2), .PERF_W(16)) dut (
      .clk(clk), .rstd(rstd), .valid_d(valid_d), .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .load_e(load_e), .rd_e(rd_e),
      .jon10(jon10), .jon2(jon2), .op_w(op_w), .kill_d(kill_d),
      .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
   );

   pc_seq_ctrl #(.RESOLVE_LAT(2), .PERF_W(4)) dut_s (
      .clk(clk), .rstd(rstd), .valid_d(valid_d), .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .load_e(load_e), .rd_e(rd_e),
      .jon10(jon10_s), .jon2(jon2_s), .op_w(op_w_s), .kill_d(kill_d_s),
      .stall_cnt(stall_cnt_s), .branch_cnt(branch_cnt_s)
   );

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_d = 0; op_d = 0; rs_d = 0; rt_d = 0;
      uses_rs_d = 0; uses_rt_d = 0; load_e = 0; rd_e = 0;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   // Outputs: {jon10, jon2, kill_d}
   task automatic chk_out(input string name, input logic [1:0] e10, input logic e2, input logic ek);
      checks++;
      if ({jon10, jon2, kill_d} !== {e10, e2, ek})
         $display("FAIL %s: jon10/jon2/kill_d got %b/%b/%b expected %b/%b/%b",
                  name, jon10, jon2, kill_d, e10, e2, ek);
      else passed++;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstd = 1;
      tick(); tick();
      chk_out("reset_outputs", 2'b00, 1'b0, 1'b0);
      chk("reset_op_w", {10'd0, op_w}, 16'd0);
      chk("reset_stall_cnt", stall_cnt, 16'd0);
      chk("reset_branch_cnt", branch_cnt, 16'd0);
      rstd = 0;
      tick();
   endtask

   task automatic test_branch();
      valid_d = 1; op_d = 6'd32;
      #1 chk_out("br_idle", 2'b00, 1'b0, 1'b0);
      tick(); valid_d = 0; op_d = 0;
      chk_out("br_shadow1", 2'b01, 1'b0, 1'b1);
      tick();
      chk_out("br_shadow2", 2'b01, 1'b0, 1'b1);
      tick();
      chk_out("br_resolve", 2'b00, 1'b1, 1'b1);
      chk("br_op_w", {10'd0, op_w}, 16'd32);
      tick();
      chk_out("br_back_idle", 2'b00, 1'b0, 1'b0);
      chk("br_stall_cnt", stall_cnt, 16'd2);
      chk("br_branch_cnt", branch_cnt, 16'd1);
   endtask

   task automatic test_load_use();
      valid_d = 1; op_d = 6'd1; load_e = 1; rd_e = 5'd5; rs_d = 5'd5; uses_rs_d = 1;
      #1 chk_out("lu_rs_match", 2'b10, 1'b0, 1'b0);
      uses_rs_d = 0; rs_d = 5'd3; rt_d = 5'd5; uses_rt_d = 1;
      #1 chk_out("lu_rt_match", 2'b10, 1'b0, 1'b0);
      uses_rt_d = 0;
      #1 chk_out("lu_not_used", 2'b00, 1'b0, 1'b0);
      rd_e = 5'd0; rs_d = 5'd0; uses_rs_d = 1;
      #1 chk_out("lu_rd_zero", 2'b00, 1'b0, 1'b0);
      rd_e = 5'd5; rs_d = 5'd5; load_e = 0;
      #1 chk_out("lu_no_load", 2'b00, 1'b0, 1'b0);
      load_e = 1; valid_d = 0;
      #1 chk_out("lu_invalid", 2'b00, 1'b0, 1'b0);
      valid_d = 1;
      tick();
      chk_out("lu_held", 2'b10, 1'b0, 1'b0);
      chk("lu_stall_cnt", stall_cnt, 16'd3);
      idle_inputs();
   endtask

   task automatic test_hazard_cf();
      valid_d = 1; op_d = 6'd40; load_e = 1; rd_e = 5'd7; rs_d = 5'd7; uses_rs_d = 1;
      #1 chk_out("hcf_hazard", 2'b10, 1'b0, 1'b0);
      tick();
      load_e = 0;
      #1 chk_out("hcf_not_accepted", 2'b00, 1'b0, 1'b0);
      tick(); idle_inputs();
      chk_out("hcf_shadow", 2'b01, 1'b0, 1'b1);
      tick(); tick();
      chk_out("hcf_resolve", 2'b00, 1'b1, 1'b1);
      chk("hcf_op_w", {10'd0, op_w}, 16'd40);
      tick();
      chk("hcf_stall_cnt", stall_cnt, 16'd6);
      chk("hcf_branch_cnt", branch_cnt, 16'd2);
   endtask

   task automatic test_back_to_back();
      valid_d = 1; op_d = 6'd42;
      tick(); tick(); tick();
      chk_out("b2b_resolve1", 2'b00, 1'b1, 1'b1);
      chk("b2b_op_w1", {10'd0, op_w}, 16'd42);
      tick();
      chk_out("b2b_idle_gap", 2'b00, 1'b0, 1'b0);
      tick(); idle_inputs();
      chk_out("b2b_shadow2", 2'b01, 1'b0, 1'b1);
      tick(); tick();
      chk_out("b2b_resolve2", 2'b00, 1'b1, 1'b1);
      chk("b2b_op_w2", {10'd0, op_w}, 16'd42);
      tick();
      chk_out("b2b_idle", 2'b00, 1'b0, 1'b0);
      chk("b2b_branch_cnt", branch_cnt, 16'd4);
      chk("b2b_stall_cnt", stall_cnt, 16'd10);
   endtask

   task automatic test_reset_mid_shadow();
      valid_d = 1; op_d = 6'd33;
      tick(); idle_inputs();
      chk_out("rms_shadow", 2'b01, 1'b0, 1'b1);
      #2 rstd = 1;
      #1 chk_out("rms_async", 2'b00, 1'b0, 1'b0);
      chk("rms_op_w", {10'd0, op_w}, 16'd0);
      chk("rms_stall_cnt", stall_cnt, 16'd0);
      chk("rms_branch_cnt", branch_cnt, 16'd0);
      #1 rstd = 0;
      #1 valid_d = 1; op_d = 6'd1;
      tick();
      chk_out("rms_after", 2'b00, 1'b0, 1'b0);
      idle_inputs();
   endtask

   task automatic test_saturation();
      valid_d = 1; op_d = 6'd2; load_e = 1; rd_e = 5'd9; rt_d = 5'd9; uses_rt_d = 1;
      for (int i = 0; i < 15; i++) tick();
      chk("sat_stall_15", {12'd0, stall_cnt_s}, 16'd15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_stall_held", {12'd0, stall_cnt_s}, 16'd15);
      chk("sat_wide_stall", stall_cnt, 16'd20);
      chk("sat_branch", {12'd0, branch_cnt_s}, 16'd0);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rstd = 1;
      #1;
      test_reset();
      test_branch();
      test_load_use();
      test_hazard_cf();
      test_back_to_back();
      test_reset_mid_shadow();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
